mips_mdu_seq: RTL
=================

MIPS_MDU_SEQ -- requirements
Module: mips_mdu_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request an operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, mdu_op_t (2 bits): MULT=0, MULTU=1, DIV=2, DIVU=3.
REQ-005 SHALL have port rs_val, input, 32 bits: multiplicand or dividend.
REQ-006 SHALL have port rt_val, input, 32 bits: multiplier or divisor.
REQ-007 SHALL have port abort, input, 1 bit: cancel the operation in flight.
REQ-008 SHALL have ports hi_we and lo_we, inputs, 1 bit each: MTHI/MTLO write strobes.
REQ-009 SHALL have port wdata, input, 32 bits: data for MTHI/MTLO.
REQ-010 SHALL have port busy, output, 1 bit: operation in flight; the core stalls on MFHI/MFLO while it is high.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port div_by_zero, output, 1 bit: valid while done is high.
REQ-013 SHALL have ports hi and lo, outputs, 32 bits each: architectural HI and LO registers.

Function
REQ-014 SHALL implement states IDLE, RUN, FIX and DONE.
REQ-015 Edge N with start=1 in IDLE: latch |rs|/|rt| (signed ops) or raw values (unsigned ops), latch op and result sign(s), clear counter, go to RUN.
REQ-016 busy SHALL be high in RUN, FIX and DONE, and low in IDLE.
REQ-017 RUN SHALL perform one iteration per cycle, 32 iterations (edges N+1..N+32), then go to FIX.
- Multiply: shift-add into a 64-bit product.
- Divide: restoring shift-subtract; quotient to lo, remainder to hi.
REQ-018 FIX (edge N+33) SHALL apply sign correction, write hi/lo, set done=1 and go to DONE.
- MULT: negate the 64-bit product if the operand signs differ.
- DIV: quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
REQ-019 DONE (edge N+34) SHALL clear done and div_by_zero and return to IDLE; done is high for exactly one cycle.
REQ-020 DIV/DIVU with rt_val=0 SHALL skip RUN.
- At edge N+1: hi=rs_val, lo=32'hFFFF_FFFF, div_by_zero=1, done=1, go to DONE.
- At edge N+2: return to IDLE.
REQ-021 DIV 0x8000_0000 / 0xFFFF_FFFF SHALL yield lo=0x8000_0000, hi=0, with no flag raised.
REQ-022 start outside IDLE SHALL be ignored, with no queuing.
REQ-023 abort in RUN SHALL return the block to IDLE at the next edge.
- hi/lo unchanged; done never pulses.
- abort in IDLE, FIX or DONE has no effect.
REQ-024 hi_we/lo_we SHALL write wdata only in IDLE and only when start=0.
- When coincident with an accepted start, the start wins and the write is dropped.
- Writes while busy are dropped.
REQ-025 hi/lo SHALL change only at FIX, at the divide-by-zero edge, or on an accepted MTHI/MTLO write.

Reset
REQ-026 rst_n=0 SHALL immediately force the following, regardless of the edge:
- state=IDLE, busy=0, done=0, div_by_zero=0;
- hi=0, lo=0;
- internal counter and accumulators cleared.
REQ-027 Reset mid-operation SHALL discard the operation; after release, the first start is accepted normally.

Structure
REQ-028 mips_pkg SHALL hold mdu_op_t, the mdu_state_t enum and MDU_ITERATIONS=32.
REQ-029 The single-iteration add/subtract step SHALL be one combinational sub-module, mips_mdu_step.
- It is selected by a mul/div bit.
- Its inputs are the accumulator and the operand; its outputs are the next accumulator and the quotient bit.

Verification
REQ-030 MULTU rs=0xFFFF_FFFF, rt=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001; done high exactly at edge start+33 for one cycle.
REQ-031 MULT rs=-3, rt=5 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFF1. DIV rs=-7, rt=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
REQ-032 DIVU rs=100, rt=0 -> done at start+1 with div_by_zero=1, hi=0x64, lo=0xFFFF_FFFF; busy low by start+2.
REQ-033 DIV rs=0x8000_0000, rt=0xFFFF_FFFF -> lo=0x8000_0000, hi=0; div_by_zero=0.
REQ-034 Abort and dropped requests:
- start MULTU; abort at cycle 10 -> busy low next cycle, no done, hi/lo keep prior values.
- A start asserted during busy -> ignored.
- hi_we asserted during busy -> dropped.
REQ-035 Reset and coincident requests:
- Assert rst_n=0 mid-RUN -> all outputs zero immediately.
- Then hi_we with wdata=0x1234 and start in the same IDLE cycle -> start accepted, hi not written by the MTHI.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS multiply/divide unit
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    localparam int MDU_ITERATIONS = 32;

endpackage

// File: rtl/mips_mdu_step.sv
// rtl/mips_mdu_step.sv - one shift-add (multiply) or restoring shift-subtract (divide) iteration
module mips_mdu_step (
    input  logic        is_div_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] operand_i,
    output logic [63:0] acc_o,
    output logic        q_bit_o
);

    logic [32:0] sum;
    logic [33:0] diff;

    // Divide keeps {remainder, dividend}; the freed LSB is left zero for the quotient bit.
    always_comb begin
        sum     = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, operand_i} : 33'd0);
        diff    = {1'b0, acc_i[63:31]} - {2'b00, operand_i};
        q_bit_o = 1'b0;
        acc_o   = '0;
        if (is_div_i) begin
            q_bit_o = ~diff[33];
            acc_o   = {(diff[33] ? acc_i[62:31] : diff[31:0]), acc_i[30:0], 1'b0};
        end else begin
            acc_o   = {sum, acc_i[31:1]};
        end
    end

endmodule

// File: rtl/mips_mdu_seq.sv
// rtl/mips_mdu_seq.sv - sequential 32-iteration MIPS multiply/divide unit with HI/LO registers
module mips_mdu_seq
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  mdu_op_t     op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        abort,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] LAST_ITER = 5'(MDU_ITERATIONS - 1);

    mdu_state_t  state_q;
    mdu_op_t     op_q;
    logic [4:0]  cnt_q;
    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic [31:0] opd_q;
    logic        neg_lo_q;
    logic        neg_hi_q;
    logic        dz_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;
    logic        dbz_q;

    logic        in_signed;
    logic        in_div;
    logic        in_dz;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [63:0] step_acc;
    logic        step_q;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        in_signed = ~op[0];
        in_div    = op[1];
        in_dz     = in_div && (rt_val == 32'd0);
        rs_mag    = (in_signed && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
        rt_mag    = (in_signed && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
        acc_d     = {step_acc[63:1], step_acc[0] | step_q};
        prod_fix  = neg_lo_q ? (64'd0 - acc_q) : acc_q;
        quo_fix   = neg_lo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_fix   = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end

    mips_mdu_step u_step (
        .is_div_i  (op_q[1]),
        .acc_i     (acc_q),
        .operand_i (opd_q),
        .acc_o     (step_acc),
        .q_bit_o   (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MULT;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        cnt_q    <= '0;
                        dz_q     <= in_dz;
                        acc_q    <= {32'd0, (in_div ? rs_mag : rt_mag)};
                        // A divide by zero reports the raw dividend, so keep it unsigned here.
                        opd_q    <= in_dz ? rs_val : (in_div ? rt_mag : rs_mag);
                        neg_lo_q <= in_signed && (rs_val[31] ^ rt_val[31]);
                        neg_hi_q <= in_signed && rs_val[31];
                        state_q  <= ST_RUN;
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                ST_RUN: begin
                    if (dz_q) begin
                        hi_q    <= opd_q;
                        lo_q    <= 32'hFFFF_FFFF;
                        done_q  <= 1'b1;
                        dbz_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (abort) begin
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == LAST_ITER) state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (op_q[1]) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
